shake_squeeze_ctrl: RTL
=======================

# shake_squeeze_ctrl

Output-phase sequencer for the SHAKE256 core. Once absorption completes, it streams the 1088-bit rate portion of the Keccak state as 64-bit lanes over a valid/ready port. Whenever a rate block is exhausted and more output is still owed, it schedules a 24-round permutation by stepping the round datapath. It sits between the absorb control unit and the external output interface, and owns the round-enable and round-index controls during squeeze.

## Interface
Parameters:
- LANE_W, 64, output word width (one Keccak lane)
- RATE_WORDS, 17, lanes per rate block (17 × 64 = 1088)
- ROUNDS, 24, permutation rounds per block
- LEN_W, 12, width of requested output length in lanes

Ports (reset is asynchronous, active-low, named `reset`; clock is named `clock`):
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin squeezing; sampled in IDLE only
- out_words  input  LEN_W  number of lanes to emit; sampled with start
- state_in  input  RATE_WORDS*LANE_W  rate portion of core state; lane i = state_in[64i+63:64i]
- round_en  output  1  core applies one round at this clock edge
- round_idx  output  5  round constant index for current round_en
- dout  output  LANE_W  current output lane
- dout_valid  output  1  dout holds a valid lane
- dout_ready  input  1  consumer accepts dout
- dout_last  output  1  dout is the final requested lane
- busy  output  1  squeeze in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset values: all outputs 0; state IDLE; remaining = 0, word_idx = 0, round_cnt = 0.
- States: IDLE, EMIT, PERMUTE, FIN.
- IDLE:
  - On start with out_words ≠ 0: latch remaining = out_words, word_idx = 0, go to EMIT.
  - On start with out_words = 0: go to FIN; no lanes are emitted.
- EMIT:
  - dout = lane word_idx of state_in; dout_valid = 1; dout_last = (remaining == 1).
  - A handshake (valid & ready) decrements remaining and increments word_idx.
  - After a handshake with remaining == 1, go to FIN. This check has priority.
  - Otherwise, after a handshake with word_idx == RATE_WORDS−1, go to PERMUTE with round_cnt = 0.
  - Otherwise, stay in EMIT.
- PERMUTE:
  - round_en = 1 and round_idx = round_cnt on every cycle; round_cnt increments.
  - After the cycle with round_cnt == ROUNDS−1, go to EMIT with word_idx = 0.
  - dout_valid = 0 throughout.
- FIN: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- busy = 1 in EMIT and PERMUTE only.
- start outside IDLE is ignored; it is not queued.
- Once dout_valid rises, it and dout stay stable until a handshake. state_in must not change in EMIT; this holds because the core only updates on round_en.
- remaining is never decremented below 0.
- word_idx wraps only through PERMUTE; it never exceeds RATE_WORDS−1.
- Exact-multiple lengths (out_words = 17k): no trailing permutation after the final lane.
- Asynchronous reset mid-EMIT or mid-PERMUTE aborts immediately: state IDLE, all outputs 0, no done pulse.

## Timing
- start high in cycle 0 (IDLE) → dout_valid = 1 in cycle 1. Latency is 1 cycle.
- With dout_ready held high: one lane per cycle.
- Lane 16 accepted in cycle n → round_en high cycles n+1 … n+24 with round_idx 0 … 23 → next lane valid in cycle n+25.
- Last lane accepted in cycle m → done = 1 and busy = 0 in cycle m+1. A new start is accepted from cycle m+2.
- out_words = 0: start in cycle 0 → done in cycle 1.
- round_en and round_idx are registered state decodes (no input-to-output combinational path).
- dout is a mux of state_in selected by the registered word_idx.
- dout_last depends only on the registered count remaining.

## Structure
- Shared package shake_pkg holds:
  - LANE_W, RATE_WORDS, ROUNDS
  - the squeeze state enum (IDLE/EMIT/PERMUTE/FIN), shared with the absorb controller's state typedef
- One sub-module, rate_lane_mux: RATE_WORDS-to-1 lane select on word_idx, also reusable by the absorb path.
- Counters and FSM stay in this module.

## Test plan
- out_words = 5, ready always high: lanes 0–4 of state_in appear in cycles 1–5; dout_last only in cycle 5; done in cycle 6; round_en never asserted.
- out_words = 17: 17 lanes, no round_en after the last lane; done in cycle 18.
- out_words = 18: lanes 0–16, then 24 round_en cycles with round_idx 0–23, then lane 0 of the new state_in with dout_last = 1; done follows.
- Random dout_ready stalls, out_words = 40: dout and dout_valid stable across every stall; exactly 40 handshakes; 2 permutations.
- out_words = 0: done pulses in cycle 1; dout_valid never rises. Second start while busy: ignored, and the lane count is unchanged.
- reset low mid-PERMUTE (round_idx = 10): all outputs 0 immediately; no done pulse; a fresh start of 3 lanes then runs cleanly.

Source files
------------

// File: rtl/shake_pkg.sv
// shake_pkg: shared SHAKE256 constants and controller state encoding
package shake_pkg;
  localparam int LANE_W = 64;
  localparam int RATE_WORDS = 17;
  localparam int ROUNDS = 24;
  typedef enum logic [1:0] {IDLE, EMIT, PERMUTE, FIN} squeeze_state_e;
endpackage

// File: rtl/rate_lane_mux.sv
// rate_lane_mux: selects one lane of the rate block by index
module rate_lane_mux
  import shake_pkg::*;
#(
  parameter int W = LANE_W,
  parameter int N = RATE_WORDS,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0]   lanes_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]     lane_o
);
  // out-of-range indices yield zero rather than aliasing another lane
  always_comb begin
    lane_o = '0;
    for (int i = 0; i < N; i++) lane_o = (sel_i == SEL_W'(i)) ? lanes_i[i*W +: W] : lane_o;
  end
endmodule

// File: rtl/shake_squeeze_ctrl.sv
// shake_squeeze_ctrl: streams SHAKE256 rate lanes and schedules permutations between blocks
module shake_squeeze_ctrl
  import shake_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             out_words,
  input  logic [RATE_WORDS*LANE_W-1:0] state_in,
  output logic                         round_en,
  output logic [4:0]                   round_idx,
  output logic [LANE_W-1:0]            dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_last,
  output logic                         busy,
  output logic                         done
);
  localparam logic [4:0] LAST_LANE = 5'(RATE_WORDS - 1);
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  squeeze_state_e state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [4:0] widx_q, widx_d, rcnt_q, rcnt_d;
  logic [LANE_W-1:0] lane;
  logic hs;
  assign hs = dout_valid && dout_ready;
  rate_lane_mux u_mux (
    .lanes_i(state_in),
    .sel_i  (widx_q),
    .lane_o (lane)
  );
  // dout is forced to zero whenever no lane is being offered
  assign dout = dout_valid ? lane : '0;
  // next-state: the last-lane check wins over the block-exhausted check, so exact multiples skip the trailing permutation
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    widx_d = widx_q;
    rcnt_d = rcnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = (out_words != '0) ? EMIT : FIN;
        rem_d = out_words;
        widx_d = '0;
      end
      EMIT: if (hs) begin
        rem_d = rem_q - ONE;
        widx_d = (widx_q == LAST_LANE) ? '0 : widx_q + 5'd1;
        rcnt_d = '0;
        state_d = (rem_q == ONE) ? FIN : (widx_q == LAST_LANE) ? PERMUTE : EMIT;
      end
      PERMUTE: begin
        rcnt_d = rcnt_q + 5'd1;
        state_d = (rcnt_q == LAST_ROUND) ? EMIT : PERMUTE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered output decodes of the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      widx_q <= '0;
      rcnt_q <= '0;
      round_en <= 1'b0;
      round_idx <= '0;
      dout_valid <= 1'b0;
      dout_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      widx_q <= widx_d;
      rcnt_q <= rcnt_d;
      round_en <= state_d == PERMUTE;
      round_idx <= (state_d == PERMUTE) ? rcnt_d : '0;
      dout_valid <= state_d == EMIT;
      dout_last <= (state_d == EMIT) && (rem_d == ONE);
      busy <= (state_d == EMIT) || (state_d == PERMUTE);
      done <= state_d == FIN;
    end
  end
endmodule
